// File: rtl/rand_chk_pkg.sv
// Shared definitions for the LFSR stream checker: state encoding, default taps
// and the single-step LFSR next-value function.
package rand_chk_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } chk_state_t;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

  // Shift left; the new LSB is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] value, input logic [7:0] taps);
    return {value[6:0], ^(value & taps)};
  endfunction

endpackage

// File: rtl/rand_lfsr_step.sv
// Combinational single-step LFSR advance: next_value = lfsr_next(value, TAPS).
module rand_lfsr_step
  import rand_chk_pkg::*;
#(
  parameter logic [7:0] TAPS = DEFAULT_TAPS
) (
  input  logic [7:0] value,
  output logic [7:0] next_value
);

  assign next_value = lfsr_next(value, TAPS);

endmodule

// File: rtl/rand_stream_checker.sv
// Self-synchronising checker for an 8-bit LFSR byte stream; all outputs registered, one cycle after the sample.
// Optional RAND_CHK_STATS_EN adds sample_count (valid samples in LOCK) and lock_loss (LOCK->HUNT count).
module rand_stream_checker
  import rand_chk_pkg::*;
#(
  parameter logic [7:0]  TAPS         = DEFAULT_TAPS,
  parameter int unsigned LOCK_MATCHES = 4,
  parameter int unsigned LOSS_MISSES  = 3,
  parameter int unsigned ERR_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       num_in,
  input  logic             num_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       predicted
`ifdef RAND_CHK_STATS_EN
  ,
  output logic [ERR_W-1:0] sample_count,
  output logic [7:0]       lock_loss
`endif
);

  localparam logic [3:0] LOCK_M = 4'(LOCK_MATCHES);
  localparam logic [3:0] LOSS_M = 4'(LOSS_MISSES);

  chk_state_t       state, state_nxt;
  logic [3:0]       match_cnt, match_nxt;
  logic [3:0]       miss_cnt, miss_nxt;
  logic [7:0]       pred_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             pulse_nxt;
  logic [7:0]       seed_step;
  logic [7:0]       pred_step;
  logic             is_match;

  rand_lfsr_step #(.TAPS(TAPS)) u_seed_step (
    .value      (num_in),
    .next_value (seed_step)
  );

  rand_lfsr_step #(.TAPS(TAPS)) u_pred_step (
    .value      (predicted),
    .next_value (pred_step)
  );

  assign is_match = (num_in == predicted);

`ifdef RAND_CHK_STATS_EN
  logic [ERR_W-1:0] samp_nxt;
  logic [7:0]       loss_nxt;
`endif

  always_comb begin
    state_nxt = state;
    pred_nxt  = predicted;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    err_nxt   = err_count;
    pulse_nxt = 1'b0;
`ifdef RAND_CHK_STATS_EN
    samp_nxt  = sample_count;
    loss_nxt  = lock_loss;
`endif
    if (num_valid) begin
      case (state)
        HUNT: begin
          // All-zero is the LFSR lock-up value and can never seed a valid stream.
          if (num_in != 8'd0) begin
            pred_nxt  = seed_step;
            match_nxt = 4'd0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (is_match) begin
            pred_nxt  = pred_step;
            match_nxt = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_M) begin
              state_nxt = LOCK;
              miss_nxt  = 4'd0;
            end
          end else if (num_in != 8'd0) begin
            pred_nxt  = seed_step;
            match_nxt = 4'd0;
          end else begin
            match_nxt = 4'd0;
            state_nxt = HUNT;
          end
        end
        LOCK: begin
          // Flywheel: keep predicting from our own sequence, never reseed from input.
          pred_nxt = pred_step;
`ifdef RAND_CHK_STATS_EN
          if (sample_count != '1) samp_nxt = sample_count + ERR_W'(1);
`endif
          if (is_match) begin
            miss_nxt = 4'd0;
          end else begin
            pulse_nxt = 1'b1;
            if (err_count != '1) err_nxt = err_count + ERR_W'(1);
            miss_nxt = miss_cnt + 4'd1;
            if (miss_cnt + 4'd1 == LOSS_M) begin
              state_nxt = HUNT;
`ifdef RAND_CHK_STATS_EN
              if (lock_loss != 8'hFF) loss_nxt = lock_loss + 8'd1;
`endif
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      predicted <= 8'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      err_count <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      predicted <= pred_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      err_count <= err_nxt;
      err_pulse <= pulse_nxt;
      locked    <= (state_nxt == LOCK);
    end
  end

`ifdef RAND_CHK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_count <= '0;
      lock_loss    <= 8'd0;
    end else begin
      sample_count <= samp_nxt;
      lock_loss    <= loss_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rand_stream_checker.sv
// Scoreboard bench for rand_stream_checker: a behavioural model pushes expected outputs per driven cycle.
module tb_rand_stream_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  num_in = 8'd0;
  logic        num_valid = 1'b0;

  logic        locked, err_pulse, locked_s, err_pulse_s;
  logic [15:0] err_count;
  logic [3:0]  err_count_s;
  logic [7:0]  predicted, predicted_s;
`ifdef RAND_CHK_STATS_EN
  logic [15:0] sample_count;
  logic [3:0]  sample_count_s;
  logic [7:0]  lock_loss, lock_loss_s;
`endif

  always #20 clk = ~clk;

  rand_stream_checker dut (
    .clk(clk), .reset(reset), .num_in(num_in), .num_valid(num_valid),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .predicted(predicted)
`ifdef RAND_CHK_STATS_EN
    , .sample_count(sample_count), .lock_loss(lock_loss)
`endif
  );

  rand_stream_checker #(.ERR_W(4)) dut_s (
    .clk(clk), .reset(reset), .num_in(num_in), .num_valid(num_valid),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .predicted(predicted_s)
`ifdef RAND_CHK_STATS_EN
    , .sample_count(sample_count_s), .lock_loss(lock_loss_s)
`endif
  );

  typedef struct packed {
    logic        lk;
    logic        pulse;
    logic [15:0] err;
    logic [3:0]  err4;
    logic [7:0]  pred;
    logic        lk4;
    logic [7:0]  pred4;
`ifdef RAND_CHK_STATS_EN
    logic [15:0] samp;
    logic [3:0]  samp4;
    logic [7:0]  loss;
    logic [7:0]  loss4;
`endif
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   pulses_seen = 0;

  // Reference model state
  int         m_st = 0;
  logic [7:0] m_pred = 8'd0;
  int         m_match = 0, m_miss = 0, m_err = 0, m_samp = 0, m_loss = 0;
  logic       m_pulse = 1'b0;

  function automatic logic [7:0] ref_next(input logic [7:0] x);
    ref_next = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.lk = locked; o.pulse = err_pulse; o.err = err_count; o.err4 = err_count_s;
    o.pred = predicted; o.lk4 = locked_s; o.pred4 = predicted_s;
`ifdef RAND_CHK_STATS_EN
    o.samp = sample_count; o.samp4 = sample_count_s; o.loss = lock_loss; o.loss4 = lock_loss_s;
`endif
    return o;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    logic [31:0] v;
    e.lk = (m_st == 2); e.pulse = m_pulse; e.pred = m_pred;
    e.lk4 = e.lk; e.pred4 = m_pred;
    v = m_err;
    e.err  = (m_err > 65535) ? 16'hFFFF : v[15:0];
    e.err4 = (m_err > 15) ? 4'hF : v[3:0];
`ifdef RAND_CHK_STATS_EN
    v = m_samp;
    e.samp  = (m_samp > 65535) ? 16'hFFFF : v[15:0];
    e.samp4 = (m_samp > 15) ? 4'hF : v[3:0];
    v = m_loss;
    e.loss  = (m_loss > 255) ? 8'hFF : v[7:0];
    e.loss4 = e.loss;
`endif
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    reset = r; num_valid = v; num_in = d;
    m_pulse = 1'b0;
    if (r) begin
      m_st = 0; m_pred = 8'd0; m_match = 0; m_miss = 0; m_err = 0; m_samp = 0; m_loss = 0;
    end else if (v) begin
      case (m_st)
        0: if (d != 8'd0) begin m_pred = ref_next(d); m_match = 0; m_st = 1; end
        1: begin
          if (d == m_pred) begin
            m_pred = ref_next(m_pred); m_match++;
            if (m_match == 4) begin m_st = 2; m_miss = 0; end
          end else if (d != 8'd0) begin
            m_pred = ref_next(d); m_match = 0;
          end else begin
            m_st = 0;
          end
        end
        default: begin
          m_samp++;
          if (d != m_pred) begin
            m_pulse = 1'b1; m_err++; m_miss++;
            if (m_miss == 3) begin m_st = 0; m_loss++; end
          end else begin
            m_miss = 0;
          end
          m_pred = ref_next(m_pred);
        end
      endcase
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    obs_q.push_back(observe());
    if (err_pulse === 1'b1) pulses_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  // Seed with 0x01 and follow with four correct successors (1 seed + 4 matches).
  task automatic acquire();
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, x);
      x = ref_next(x);
    end
  endtask

  task automatic test_reset();
    obs_t e, o;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h5A);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL reset_seq got %h want %h", o, e); end
    end
    n_vec++;
    if ({locked, err_pulse, err_count, predicted} !== 26'd0) begin
      n_fail++; $display("FAIL reset_state got %h want 0", {locked, err_pulse, err_count, predicted});
    end
  endtask

  task automatic test_lock_acquire();
    obs_t e, o;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h04);
    step(1'b0, 1'b1, 8'h08);
    n_vec++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL early_lock got %b want 0", locked); end
    step(1'b0, 1'b1, 8'h11);
    n_vec++;
    if ({locked, predicted, err_count} !== {1'b1, 8'h23, 16'h0000}) begin
      n_fail++; $display("FAIL lock_acquire got lk=%b pred=%h err=%h want lk=1 pred=23 err=0", locked, predicted, err_count);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL lock_acquire_seq got %h want %h", o, e); end
    end
  endtask

  task automatic test_single_error();
    obs_t e, o;
    int p0;
    logic [7:0] x;
    p0 = pulses_seen;
    step(1'b0, 1'b1, 8'h23);
    step(1'b0, 1'b1, 8'hFF);
    x = 8'h8E;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, x);
      x = ref_next(x);
    end
    n_vec++;
    if ({pulses_seen - p0, locked, err_count} !== {32'd1, 1'b1, 16'd1}) begin
      n_fail++; $display("FAIL single_error got pulses=%0d lk=%b err=%0d want 1 1 1", pulses_seen - p0, locked, err_count);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL single_error_seq got %h want %h", o, e); end
    end
  endtask

  task automatic test_loss();
    obs_t e, o;
    int p0;
    step(1'b1, 1'b0, 8'h00);
    acquire();
    p0 = pulses_seen;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, m_pred ^ 8'h5A);
    n_vec++;
    if ({pulses_seen - p0, locked, err_count} !== {32'd3, 1'b0, 16'd3}) begin
      n_fail++; $display("FAIL loss got pulses=%0d lk=%b err=%0d want 3 0 3", pulses_seen - p0, locked, err_count);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL loss_seq got %h want %h", o, e); end
    end
  endtask

  task automatic test_zero_hunt();
    obs_t e, o;
    logic [7:0] x;
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    n_vec++;
    if ({locked, predicted} !== {1'b0, 8'h02}) begin
      n_fail++; $display("FAIL zero_hunt got lk=%b pred=%h want 0 02", locked, predicted);
    end
    // VERIFY reseed on a nonzero mismatch, then a zero drops back to HUNT
    step(1'b0, 1'b1, 8'h55);
    x = ref_next(8'h55);
    step(1'b0, 1'b1, x);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, ref_next(x));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL zero_hunt_seq got %h want %h", o, e); end
    end
  endtask

  task automatic test_gaps();
    obs_t e, o;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h02);
    idle(5);
    step(1'b0, 1'b1, 8'h04);
    step(1'b0, 1'b1, 8'h08);
    step(1'b0, 1'b1, 8'h11);
    n_vec++;
    if ({locked, predicted} !== {1'b1, 8'h23}) begin
      n_fail++; $display("FAIL gaps got lk=%b pred=%h want 1 23", locked, predicted);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL gaps_seq got %h want %h", o, e); end
    end
  endtask

  task automatic test_saturation();
    obs_t e, o;
    step(1'b1, 1'b0, 8'h00);
    for (int r = 0; r < 7; r++) begin
      acquire();
      for (int i = 0; i < ((r < 6) ? 3 : 2); i++) step(1'b0, 1'b1, ~m_pred);
    end
    n_vec++;
    if ({err_count_s, err_count, locked} !== {4'hF, 16'd20, 1'b1}) begin
      n_fail++; $display("FAIL saturation got err4=%h err16=%0d lk=%b want F 20 1", err_count_s, err_count, locked);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL saturation_seq got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_in_lock();
    obs_t e, o;
    n_vec++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL pre_reset_lock got %b want 1", locked); end
    step(1'b1, 1'b1, m_pred);
    n_vec++;
    if ({locked, err_pulse, err_count, predicted, err_count_s} !== 30'd0) begin
      n_fail++; $display("FAIL reset_in_lock got lk=%b p=%b err=%h pred=%h want all 0", locked, err_pulse, err_count, predicted);
    end
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h40);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL reset_in_lock_seq got %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_single_error();
    test_loss();
    test_zero_hunt();
    test_gaps();
    test_saturation();
    test_reset_in_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
